src_control_unit: RTL and testbench

//  Hardwired Moore sequencer that drives the DataPath control inputs: fetch, then per-class execute steps.

---
 rtl/src_control_unit.sv | 162 ++++++++++++++++
 tb/tb_src_control_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/src_control_unit.sv
// Hardwired Moore control sequencer for the DataPath: fetch T0-T2, then per-class execute steps T3-T7.
// Latency: outputs decode combinationally from the current state and IR; the state advances one step per clock.
// Backpressure: none; stop is honoured only at an instruction boundary and resume leaves HALT.
// Ports: clock/clear (async active-low), IR, CON, stop, resume in; DataPath strobes, ops, run, tstep out.
// Optional feature: define SRC_SSTEP_EN to add the step input and a WAIT state between instructions.
`default_nettype none
module src_control_unit #(
    parameter int OPW = 5,
    parameter logic [OPW-1:0] OP_ADD = 5'b00011
) (
    input  logic           clock,
    input  logic           clear,
    input  logic [31:0]    IR,
    input  logic           CON,
    input  logic           stop,
    input  logic           resume,
`ifdef SRC_SSTEP_EN
    input  logic           step,
`endif
    output logic           PCout, PCin, IncPC,
    output logic           MARin, MDRin, MDRout, Read, Write,
    output logic           IRin, RYin, RZin, RZHIout, RZLOout,
    output logic           HIin, HIout, LOin, LOout,
    output logic           PORTin, PORTout,
    output logic           gra, grb, grc, rin, rout, BAout, cout, conin,
    output logic [OPW-1:0] ops,
    output logic           run,
    output logic [2:0]     tstep
);
    // T0..T7 occupy codes 0..7 so tstep is simply the low three state bits.
    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
        T4 = 4'd4, T5 = 4'd5, T6 = 4'd6, T7 = 4'd7,
        RST = 4'd8, HALT = 4'd9
`ifdef SRC_SSTEP_EN
        , WAIT = 4'd10
`endif
    } state_t;

    state_t state, state_nxt, end_nxt;
    logic [3:0] state_bits;

    logic [OPW-1:0] op;
    logic is_rtype, is_imm, is_ldi, is_ld, is_st, is_muldiv, is_negnot;
    logic is_br, is_jr, is_in, is_out, is_mfhi, is_mflo, is_halt, is_short;
    logic last_step;
    logic unused_ir;

    assign op         = IR[31 -: OPW];
    assign unused_ir  = ^IR[31-OPW:0];
    assign state_bits = state;

    assign is_rtype  = (op >= 5'b00011) && (op <= 5'b01011);
    assign is_imm    = (op >= 5'b01100) && (op <= 5'b01110);
    assign is_ldi    = (op == 5'b00001);
    assign is_ld     = (op == 5'b00000);
    assign is_st     = (op == 5'b00010);
    assign is_muldiv = (op == 5'b01111) || (op == 5'b10000);
    assign is_negnot = (op == 5'b10001) || (op == 5'b10010);
    assign is_br     = (op == 5'b10011);
    assign is_jr     = (op == 5'b10100);
    assign is_in     = (op == 5'b10110);
    assign is_out    = (op == 5'b10111);
    assign is_mfhi   = (op == 5'b11000);
    assign is_mflo   = (op == 5'b11001);
    assign is_halt   = (op == 5'b11011);
    // Everything without a multi-step execute phase (incl. nop, jal, 11100-11111) ends at T3.
    assign is_short  = !(is_rtype || is_imm || is_ldi || is_ld || is_st ||
                         is_muldiv || is_negnot || is_br);

    // T7 always ends, so an IR that changes mid-instruction can never run past the last step.
    assign last_step = ((state == T3) && is_short) ||
                       ((state == T4) && is_negnot) ||
                       ((state == T5) && (is_rtype || is_imm || is_ldi)) ||
                       ((state == T6) && (is_muldiv || is_br)) ||
                       (state == T7);

`ifdef SRC_SSTEP_EN
    assign end_nxt = stop ? HALT : WAIT;
`else
    assign end_nxt = stop ? HALT : T0;
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= RST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST:  state_nxt = T0;
            T0:   state_nxt = T1;
            T1:   state_nxt = T2;
            T2:   state_nxt = T3;
            T3, T4, T5, T6, T7: begin
                if ((state == T3) && is_halt) state_nxt = HALT;
                else if (last_step)           state_nxt = end_nxt;
                else                          state_nxt = state_t'(state_bits + 4'd1);
            end
            HALT: if (resume && !stop) state_nxt = T0;
`ifdef SRC_SSTEP_EN
            WAIT: if (step) state_nxt = T0;
`endif
            default: state_nxt = RST;
        endcase
    end

    always_comb begin
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write} = '0;
        {IRin, RYin, RZin, RZHIout, RZLOout, HIin, HIout, LOin, LOout} = '0;
        {PORTin, PORTout, gra, grb, grc, rin, rout, BAout, cout, conin} = '0;
        ops   = '0;
        run   = (state != RST) && (state != HALT);
        tstep = state_bits[3] ? 3'd0 : state_bits[2:0];
        case (state)
            T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            T1: begin Read = 1'b1; MDRin = 1'b1; end
            T2: begin MDRout = 1'b1; IRin = 1'b1; end
            T3: begin
                if (is_rtype)                        begin grb = 1'b1; rout = 1'b1; RYin = 1'b1; end
                else if (is_imm || is_ldi || is_ld || is_st)
                                                     begin grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
                else if (is_muldiv)                  begin gra = 1'b1; rout = 1'b1; RYin = 1'b1; end
                else if (is_negnot)                  begin grb = 1'b1; rout = 1'b1; RZin = 1'b1; ops = op; end
                else if (is_br)                      begin gra = 1'b1; rout = 1'b1; conin = 1'b1; end
                else if (is_jr)                      begin gra = 1'b1; rout = 1'b1; PCin = 1'b1; end
                else if (is_in)                      begin PORTout = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (is_out)                     begin gra = 1'b1; rout = 1'b1; PORTin = 1'b1; end
                else if (is_mfhi)                    begin HIout = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (is_mflo)                    begin LOout = 1'b1; gra = 1'b1; rin = 1'b1; end
            end
            T4: begin
                if (is_rtype)                        begin grc = 1'b1; rout = 1'b1; RZin = 1'b1; ops = op; end
                else if (is_imm)                     begin cout = 1'b1; RZin = 1'b1; ops = op; end
                else if (is_ldi || is_ld || is_st)   begin cout = 1'b1; RZin = 1'b1; ops = OP_ADD; end
                else if (is_muldiv)                  begin grb = 1'b1; rout = 1'b1; RZin = 1'b1; ops = op; end
                else if (is_negnot)                  begin RZLOout = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (is_br)                      begin PCout = 1'b1; RYin = 1'b1; end
            end
            T5: begin
                if (is_rtype || is_imm || is_ldi)    begin RZLOout = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (is_ld || is_st)             begin RZLOout = 1'b1; MARin = 1'b1; end
                else if (is_muldiv)                  begin RZLOout = 1'b1; LOin = 1'b1; end
                else if (is_br)                      begin cout = 1'b1; RZin = 1'b1; ops = OP_ADD; end
            end
            T6: begin
                if (is_ld)                           begin Read = 1'b1; MDRin = 1'b1; end
                // st: MDR loads the source register from the bus (Read stays low).
                else if (is_st)                      begin gra = 1'b1; rout = 1'b1; MDRin = 1'b1; end
                else if (is_muldiv)                  begin RZHIout = 1'b1; HIin = 1'b1; end
                else if (is_br && CON)               begin RZLOout = 1'b1; PCin = 1'b1; end
            end
            T7: begin
                if (is_ld)                           begin MDRout = 1'b1; gra = 1'b1; rin = 1'b1; end
                else if (is_st)                      Write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_src_control_unit.sv
module tb_src_control_unit;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        CON = 1'b0, stop = 1'b0, resume = 1'b0;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
    logic IRin, RYin, RZin, RZHIout, RZLOout, HIin, HIout, LOin, LOout;
    logic PORTin, PORTout, gra, grb, grc, rin, rout, BAout, cout, conin;
    logic [4:0] ops;
    logic       run;
    logic [2:0] tstep;

    src_control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .CON(CON), .stop(stop), .resume(resume),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
        .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write),
        .IRin(IRin), .RYin(RYin), .RZin(RZin), .RZHIout(RZHIout), .RZLOout(RZLOout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .PORTin(PORTin), .PORTout(PORTout),
        .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .BAout(BAout),
        .cout(cout), .conin(conin), .ops(ops), .run(run), .tstep(tstep)
    );

    always #5 clock = ~clock;

    // Strobe masks, in the same order as the packed observation below.
    localparam logic [26:0] M_PCOUT = 27'h1 << 26, M_PCIN = 27'h1 << 25, M_INCPC = 27'h1 << 24;
    localparam logic [26:0] M_MARIN = 27'h1 << 23, M_MDRIN = 27'h1 << 22, M_MDROUT = 27'h1 << 21;
    localparam logic [26:0] M_READ = 27'h1 << 20, M_WRITE = 27'h1 << 19, M_IRIN = 27'h1 << 18;
    localparam logic [26:0] M_RYIN = 27'h1 << 17, M_RZIN = 27'h1 << 16, M_RZHIOUT = 27'h1 << 15;
    localparam logic [26:0] M_RZLOOUT = 27'h1 << 14, M_HIIN = 27'h1 << 13, M_HIOUT = 27'h1 << 12;
    localparam logic [26:0] M_LOIN = 27'h1 << 11, M_LOOUT = 27'h1 << 10, M_PORTIN = 27'h1 << 9;
    localparam logic [26:0] M_PORTOUT = 27'h1 << 8, M_GRA = 27'h1 << 7, M_GRB = 27'h1 << 6;
    localparam logic [26:0] M_GRC = 27'h1 << 5, M_RIN = 27'h1 << 4, M_ROUT = 27'h1 << 3;
    localparam logic [26:0] M_BAOUT = 27'h1 << 2, M_COUT = 27'h1 << 1, M_CONIN = 27'h1;

    localparam logic [31:0] IR_ADD = 32'h18918000, IR_SUB = 32'h20918000, IR_ADDI = 32'h60900005;
    localparam logic [31:0] IR_LD = 32'h00800054, IR_ST = 32'h10800054, IR_MUL = 32'h81100000;
    localparam logic [31:0] IR_NEG = 32'h88800000, IR_BR = 32'h99000010, IR_HALT = 32'hD8000000;

    logic [35:0] sb[$];
    logic [35:0] exp_v, got_v;
    int vectors = 0;
    int miscompares = 0;

    function automatic logic [35:0] obs();
        return {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, RYin, RZin,
                RZHIout, RZLOout, HIin, HIout, LOin, LOout, PORTin, PORTout, gra, grb, grc,
                rin, rout, BAout, cout, conin, ops, run, tstep};
    endfunction

    task automatic push_step(input logic [26:0] s, input logic [4:0] o, input logic [2:0] t);
        sb.push_back({s, o, 1'b1, t});
    endtask
    task automatic push_idle();
        sb.push_back(36'h0);
    endtask
    task automatic push_t0();
        push_step(M_PCOUT | M_MARIN | M_INCPC, 5'd0, 3'd0);
    endtask
    task automatic push_t1t2();
        push_step(M_READ | M_MDRIN, 5'd0, 3'd1);
        push_step(M_MDROUT | M_IRIN, 5'd0, 3'd2);
    endtask

    task automatic test_reset();
        int k = 0;
        push_idle(); push_idle();
        while (sb.size() > 0) begin
            @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
            if (got_v !== exp_v) begin miscompares++;
                $display("FAIL reset[%0d] got %h expected %h", k, got_v, exp_v); end
            k++;
        end
        clear = 1'b1;
        push_t0();
        while (sb.size() > 0) begin
            @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
            if (got_v !== exp_v) begin miscompares++;
                $display("FAIL reset_release got %h expected %h", got_v, exp_v); end
        end
    endtask

    // Each instruction task starts just after the negedge of an already-checked T0.
    task automatic test_alu();
        logic [31:0] irs [3] = '{IR_ADD, IR_SUB, IR_ADDI};
        for (int i = 0; i < 3; i++) begin
            int k = 0;
            IR = irs[i];
            push_t1t2();
            if (i < 2) begin
                push_step(M_GRB | M_ROUT | M_RYIN, 5'd0, 3'd3);
                push_step(M_GRC | M_ROUT | M_RZIN, irs[i][31:27], 3'd4);
            end else begin
                push_step(M_GRB | M_BAOUT | M_RYIN, 5'd0, 3'd3);
                push_step(M_COUT | M_RZIN, 5'b01100, 3'd4);
            end
            push_step(M_RZLOOUT | M_GRA | M_RIN, 5'd0, 3'd5);
            push_t0();
            while (sb.size() > 0) begin
                @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
                if (got_v !== exp_v) begin miscompares++;
                    $display("FAIL alu%0d[%0d] got %h expected %h", i, k, got_v, exp_v); end
                k++;
            end
        end
    endtask

    task automatic test_mem();
        for (int i = 0; i < 2; i++) begin
            int k = 0;
            IR = (i == 0) ? IR_LD : IR_ST;
            push_t1t2();
            push_step(M_GRB | M_BAOUT | M_RYIN, 5'd0, 3'd3);
            push_step(M_COUT | M_RZIN, 5'b00011, 3'd4);
            push_step(M_RZLOOUT | M_MARIN, 5'd0, 3'd5);
            if (i == 0) begin
                push_step(M_READ | M_MDRIN, 5'd0, 3'd6);
                push_step(M_MDROUT | M_GRA | M_RIN, 5'd0, 3'd7);
            end else begin
                push_step(M_GRA | M_ROUT | M_MDRIN, 5'd0, 3'd6);
                push_step(M_WRITE, 5'd0, 3'd7);
            end
            push_t0();
            while (sb.size() > 0) begin
                @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
                if (got_v !== exp_v) begin miscompares++;
                    $display("FAIL mem%0d[%0d] got %h expected %h", i, k, got_v, exp_v); end
                k++;
            end
        end
    endtask

    task automatic test_muldiv_neg();
        int k = 0;
        IR = IR_MUL;
        push_t1t2();
        push_step(M_GRA | M_ROUT | M_RYIN, 5'd0, 3'd3);
        push_step(M_GRB | M_ROUT | M_RZIN, 5'b10000, 3'd4);
        push_step(M_RZLOOUT | M_LOIN, 5'd0, 3'd5);
        push_step(M_RZHIOUT | M_HIIN, 5'd0, 3'd6);
        push_t0();
        while (sb.size() > 0) begin
            @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
            if (got_v !== exp_v) begin miscompares++;
                $display("FAIL mul[%0d] got %h expected %h", k, got_v, exp_v); end
            k++;
            if (sb.size() == 0 && IR == IR_MUL) begin
                IR = IR_NEG;
                push_t1t2();
                push_step(M_GRB | M_ROUT | M_RZIN, 5'b10001, 3'd3);
                push_step(M_RZLOOUT | M_GRA | M_RIN, 5'd0, 3'd4);
                push_t0();
            end
        end
    endtask

    task automatic test_branch();
        for (int c = 1; c >= 0; c--) begin
            int k = 0;
            IR = IR_BR; CON = c[0];
            push_t1t2();
            push_step(M_GRA | M_ROUT | M_CONIN, 5'd0, 3'd3);
            push_step(M_PCOUT | M_RYIN, 5'd0, 3'd4);
            push_step(M_COUT | M_RZIN, 5'b00011, 3'd5);
            push_step(c[0] ? (M_RZLOOUT | M_PCIN) : 27'h0, 5'd0, 3'd6);
            push_t0();
            while (sb.size() > 0) begin
                @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
                if (got_v !== exp_v) begin miscompares++;
                    $display("FAIL br_con%0d[%0d] got %h expected %h", c, k, got_v, exp_v); end
                k++;
            end
        end
        CON = 1'b0;
    endtask

    task automatic test_short();
        logic [31:0] irs [7] = '{32'hA0800000, 32'hB0800000, 32'hB8800000, 32'hC0800000,
                                 32'hC8800000, 32'hD0000000, 32'hF8000000};
        logic [26:0] st3 [7] = '{M_GRA | M_ROUT | M_PCIN, M_PORTOUT | M_GRA | M_RIN,
                                 M_GRA | M_ROUT | M_PORTIN, M_HIOUT | M_GRA | M_RIN,
                                 M_LOOUT | M_GRA | M_RIN, 27'h0, 27'h0};
        for (int i = 0; i < 7; i++) begin
            int k = 0;
            IR = irs[i];
            push_t1t2();
            push_step(st3[i], 5'd0, 3'd3);
            push_t0();
            while (sb.size() > 0) begin
                @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
                if (got_v !== exp_v) begin miscompares++;
                    $display("FAIL short%0d[%0d] got %h expected %h", i, k, got_v, exp_v); end
                k++;
            end
        end
    endtask

    task automatic test_stop();
        int k = 0;
        IR = IR_ADD;
        push_t1t2();
        push_step(M_GRB | M_ROUT | M_RYIN, 5'd0, 3'd3);
        push_step(M_GRC | M_ROUT | M_RZIN, 5'b00011, 3'd4);
        while (sb.size() > 0) begin
            @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
            if (got_v !== exp_v) begin miscompares++;
                $display("FAIL stop_pre[%0d] got %h expected %h", k, got_v, exp_v); end
            k++;
        end
        stop = 1'b1;                 // raised during T4: T5 must still complete
        push_step(M_RZLOOUT | M_GRA | M_RIN, 5'd0, 3'd5);
        push_idle(); push_idle();
        k = 0;
        while (sb.size() > 0) begin
            @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
            if (got_v !== exp_v) begin miscompares++;
                $display("FAIL stop_halt[%0d] got %h expected %h", k, got_v, exp_v); end
            k++;
            if (k == 3) begin resume = 1'b1; push_idle(); end   // stop wins over resume
            if (k == 4) begin stop = 1'b0; push_t0(); end
        end
        resume = 1'b0;
    endtask

    task automatic test_halt();
        int k = 0;
        IR = IR_HALT;
        push_t1t2();
        push_step(27'h0, 5'd0, 3'd3);
        push_idle(); push_idle();
        while (sb.size() > 0) begin
            @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
            if (got_v !== exp_v) begin miscompares++;
                $display("FAIL halt[%0d] got %h expected %h", k, got_v, exp_v); end
            k++;
        end
        IR = IR_ADD;
        resume = 1'b1;
        push_t0();
        while (sb.size() > 0) begin
            @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
            if (got_v !== exp_v) begin miscompares++;
                $display("FAIL halt_resume got %h expected %h", got_v, exp_v); end
        end
        resume = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k = 0;
        IR = IR_LD;
        push_t1t2();
        push_step(M_GRB | M_BAOUT | M_RYIN, 5'd0, 3'd3);
        push_step(M_COUT | M_RZIN, 5'b00011, 3'd4);
        push_step(M_RZLOOUT | M_MARIN, 5'd0, 3'd5);
        while (sb.size() > 0) begin
            @(negedge clock); exp_v = sb.pop_front(); got_v = obs(); vectors++;
            if (got_v !== exp_v) begin miscompares++;
                $display("FAIL rstmid[%0d] got %h expected %h", k, got_v, exp_v); end
            k++;
            if (k == 5) begin clear = 1'b0; push_idle(); push_idle(); end
            if (k == 7) begin clear = 1'b1; push_t0(); end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_muldiv_neg();
        test_branch();
        test_short();
        test_stop();
        test_halt();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
